// File: rtl/gnn_0_example_weight_pkg.sv
// Shared types and instruction field layout for the weight-load dispatch stage.
package gnn_0_example_weight_pkg;

  localparam int INST_BITS        = 96;
  localparam int FIELD_W          = 16;
  localparam int BYTE_LEN_LSB     = 80;
  localparam int DRAM_ADDR_LSB    = 64;
  localparam int BUF_LEN_LSB      = 48;
  localparam int BUF_ADDR_LSB     = 32;
  localparam int RSVD_LSB         = 2;
  localparam int RSVD_W           = 30;
  localparam int SIGNAL_READY_BIT = 1;
  localparam int WAIT_RELEASE_BIT = 0;

  typedef struct packed {
    logic [FIELD_W-1:0] byte_len;
    logic [FIELD_W-1:0] dram_addr;
    logic [FIELD_W-1:0] buf_len;
    logic [FIELD_W-1:0] buf_addr;
    logic [RSVD_W-1:0]  rsvd;
    logic               signal_ready;
    logic               wait_release;
  } weight_inst_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_CREDIT,
    ST_ISSUE,
    ST_BUSY,
    ST_REPORT
  } dispatch_state_e;

  // Canonical flat layout handed to the loader.
  function automatic logic [INST_BITS-1:0] pack_inst(input weight_inst_t i);
    logic [INST_BITS-1:0] w;
    w = '0;
    w[BYTE_LEN_LSB  +: FIELD_W] = i.byte_len;
    w[DRAM_ADDR_LSB +: FIELD_W] = i.dram_addr;
    w[BUF_LEN_LSB   +: FIELD_W] = i.buf_len;
    w[BUF_ADDR_LSB  +: FIELD_W] = i.buf_addr;
    w[RSVD_LSB      +: RSVD_W]  = i.rsvd;
    w[SIGNAL_READY_BIT]         = i.signal_ready;
    w[WAIT_RELEASE_BIT]         = i.wait_release;
    return w;
  endfunction

endpackage

// File: rtl/gnn_0_example_inst_fifo.sv
// First-word-fall-through instruction queue with occupancy count.
module gnn_0_example_inst_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/gnn_0_example_weight_dispatch.sv
// Credit-gated issue stage for the weight loader, one load in flight at a time.
// Optional WEIGHT_DISPATCH_PERF_EN adds busy-cycle and issue counters.
//
// state       | meaning
// ST_IDLE     | waiting for a queued instruction; pops head into hold
// ST_FETCH    | decide whether the held instruction needs a buffer credit
// ST_WAIT_CREDIT | stalled until MM releases a buffer half
// ST_ISSUE    | ap_start pulse, ctrl_* valid
// ST_BUSY     | loader running, waiting for ap_done
// ST_REPORT   | weight_ready pulse if signal_ready was set
module gnn_0_example_weight_dispatch
  import gnn_0_example_weight_pkg::*;
#(
  parameter int WEIGHT_INST_LENGTH = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int FIFO_DEPTH         = 8,
  parameter int CREDIT_W           = 3,
  parameter int INIT_CREDITS       = 2
) (
  input  logic                            kernel_clk,
  input  logic                            kernel_rst,
  input  logic                            inst_valid,
  output logic                            inst_ready,
  input  logic [WEIGHT_INST_LENGTH-1:0]   inst_data,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_offset,
  output logic                            ap_start,
  input  logic                            ap_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  output logic [WEIGHT_INST_LENGTH-1:0]   ctrl_instruction,
  input  logic                            release_valid,
  output logic                            weight_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            idle
`ifdef WEIGHT_DISPATCH_PERF_EN
  ,
  output logic [31:0]                     perf_busy_cycles,
  output logic [15:0]                     perf_inst_count
`endif
);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX  = {CREDIT_W{1'b1}};
  localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(INIT_CREDITS);

  dispatch_state_e               state;
  dispatch_state_e               state_next;
  weight_inst_t                  hold;
  logic [CREDIT_W-1:0]           credits;
  logic [WEIGHT_INST_LENGTH-1:0] fifo_dout;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          pop;
  logic                          consume;

  gnn_0_example_inst_fifo #(
    .WIDTH (WEIGHT_INST_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (kernel_clk),
    .rst   (kernel_rst),
    .push  (inst_valid),
    .pop   (pop),
    .din   (inst_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) state <= ST_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    consume    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!hold.wait_release) begin
          state_next = ST_ISSUE;
        end else if (credits != '0) begin
          consume    = 1'b1;
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_WAIT_CREDIT;
        end
      end
      ST_WAIT_CREDIT: begin
        // A release arriving while empty is handed straight to this load.
        if ((credits != '0) || release_valid) begin
          consume    = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE:  state_next = ST_BUSY;
      ST_BUSY:   if (ap_done) state_next = ST_REPORT;
      ST_REPORT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      hold             <= '0;
      ctrl_instruction <= '0;
      ctrl_addr_offset <= '0;
    end else begin
      if (pop) hold <= weight_inst_t'(fifo_dout);
      if (state_next == ST_ISSUE) begin
        ctrl_instruction <= pack_inst(hold);
        ctrl_addr_offset <= addr_offset;
      end
    end
  end

  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      credits <= CREDIT_INIT;
    end else if (release_valid && !consume) begin
      if (credits != CREDIT_MAX) credits <= credits + 1'b1;
    end else if (consume && !release_valid) begin
      credits <= credits - 1'b1;
    end
  end

  assign inst_ready   = !fifo_full;
  assign ap_start     = (state == ST_ISSUE);
  assign weight_ready = (state == ST_REPORT) && hold.signal_ready;
  assign idle         = fifo_empty && (state == ST_IDLE);

`ifdef WEIGHT_DISPATCH_PERF_EN
  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      perf_busy_cycles <= '0;
      perf_inst_count  <= '0;
    end else begin
      if ((state == ST_ISSUE) || (state == ST_BUSY)) perf_busy_cycles <= perf_busy_cycles + 1'b1;
      if (ap_start) perf_inst_count <= perf_inst_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gnn_0_example_weight_dispatch.sv
// Directed bench for the weight dispatch stage; hand-computed expectations per step.
module tb_gnn_0_example_weight_dispatch;
  import gnn_0_example_weight_pkg::*;

  logic        kernel_clk = 1'b0;
  logic        kernel_rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [95:0] inst_data;
  logic [63:0] addr_offset;
  logic        ap_start;
  logic        ap_done;
  logic [63:0] ctrl_addr_offset;
  logic [95:0] ctrl_instruction;
  logic        release_valid;
  logic        weight_ready;
  logic [3:0]  fifo_count;
  logic        idle;
`ifdef WEIGHT_DISPATCH_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_inst_count;
`endif

  int errors = 0;
  int checks = 0;

  gnn_0_example_weight_dispatch dut (
    .kernel_clk       (kernel_clk),
    .kernel_rst       (kernel_rst),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .addr_offset      (addr_offset),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ctrl_addr_offset (ctrl_addr_offset),
    .ctrl_instruction (ctrl_instruction),
    .release_valid    (release_valid),
    .weight_ready     (weight_ready),
    .fifo_count       (fifo_count),
    .idle             (idle)
`ifdef WEIGHT_DISPATCH_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_inst_count  (perf_inst_count)
`endif
  );

  always #5 kernel_clk = ~kernel_clk;

  task automatic step();
    @(posedge kernel_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (ap_start !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_start_seen"}, ap_start, 1'b1);
  endtask

  function automatic logic [95:0] mk(input logic [15:0] t, input logic sr, input logic wr);
    return {t, t ^ 16'hffff, t + 16'h0100, t | 16'h4000, {14'h0, t}, sr, wr};
  endfunction

  initial begin
    kernel_rst    = 1'b1;
    inst_valid    = 1'b0;
    ap_done       = 1'b0;
    release_valid = 1'b0;
    inst_data     = '0;
    addr_offset   = '0;
    repeat (3) step();

    chk("rst_ap_start", ap_start, 1'b0);
    chk("rst_weight_ready", weight_ready, 1'b0);
    chk("rst_ctrl_inst", ctrl_instruction, 96'h0);
    chk("rst_ctrl_addr", ctrl_addr_offset, 64'h0);
    chk("rst_fifo_count", fifo_count, 4'd0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_inst_ready", inst_ready, 1'b1);
    chk("rst_credits", dut.credits, 3'd2);

    // Stray done pulses right after reset and while idle.
    kernel_rst = 1'b0;
    step();
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    chk("t4_idle_a", idle, 1'b1);
    chk("t4_state_a", dut.state, ST_IDLE);
    chk("t4_wready_a", weight_ready, 1'b0);
    step();
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    chk("t4_state_b", dut.state, ST_IDLE);
    chk("t4_wready_b", weight_ready, 1'b0);

    // Single load: latency, ctrl contents, weight_ready pulse width.
    inst_valid  = 1'b1;
    inst_data   = mk(16'h0001, 1'b1, 1'b0);
    addr_offset = 64'h0000_0001_8000_0000;
    step();
    inst_valid = 1'b0;
    chk("t1_count", fifo_count, 4'd1);
    chk("t1_nostart_c1", ap_start, 1'b0);
    step();
    chk("t1_nostart_c2", ap_start, 1'b0);
    step();
    chk("t1_start_c3", ap_start, 1'b1);
    chk("t1_ctrl_inst", ctrl_instruction, mk(16'h0001, 1'b1, 1'b0));
    chk("t1_ctrl_addr", ctrl_addr_offset, 64'h0000_0001_8000_0000);
    addr_offset = 64'h0000_0000_dead_beef;
    step();
    chk("t1_start_pulse", ap_start, 1'b0);
    chk("t1_ctrl_addr_hold", ctrl_addr_offset, 64'h0000_0001_8000_0000);
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    chk("t1_wready", weight_ready, 1'b1);
    step();
    chk("t1_wready_pulse", weight_ready, 1'b0);
    chk("t1_idle", idle, 1'b1);

    // Three credit-gated loads with only two credits.
    for (int k = 0; k < 3; k++) begin
      inst_valid = 1'b1;
      inst_data  = mk(16'h0010 + 16'(k), 1'b0, 1'b1);
      step();
    end
    inst_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_start("t2_load");
      chk("t2_ctrl_inst", ctrl_instruction, mk(16'h0010 + 16'(k), 1'b0, 1'b1));
      step();
      ap_done = 1'b1;
      step();
      ap_done = 1'b0;
      chk("t2_no_wready", weight_ready, 1'b0);
    end
    repeat (5) step();
    chk("t2_blocked_start", ap_start, 1'b0);
    chk("t2_blocked_state", dut.state, ST_WAIT_CREDIT);
    chk("t2_credits_zero", dut.credits, 3'd0);
    release_valid = 1'b1;
    step();
    release_valid = 1'b0;
    chk("t2_third_start", ap_start, 1'b1);
    chk("t2_third_inst", ctrl_instruction, mk(16'h0012, 1'b0, 1'b1));
    chk("t2_credits_after", dut.credits, 3'd0);
    step();
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    step();

    // Release coinciding with a consume at credits=1.
    release_valid = 1'b1;
    step();
    release_valid = 1'b0;
    chk("t6_credits_one", dut.credits, 3'd1);
    inst_valid = 1'b1;
    inst_data  = mk(16'h0060, 1'b1, 1'b1);
    step();
    inst_valid = 1'b0;
    step();
    chk("t6_state_fetch", dut.state, ST_FETCH);
    release_valid = 1'b1;
    step();
    release_valid = 1'b0;
    chk("t6_start", ap_start, 1'b1);
    chk("t6_credits_kept", dut.credits, 3'd1);
    step();
`ifdef WEIGHT_DISPATCH_PERF_EN
    chk("t6_perf_inst", perf_inst_count, 16'd5);
    chk("t6_perf_busy", perf_busy_cycles, 32'd9);
`endif
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    chk("t6_wready", weight_ready, 1'b1);
    step();

    // Fill the queue while a load is busy.
    inst_valid = 1'b1;
    inst_data  = mk(16'h0070, 1'b0, 1'b0);
    step();
    inst_valid = 1'b0;
    wait_start("t3_first");
    step();
    for (int k = 0; k < 8; k++) begin
      inst_valid = 1'b1;
      inst_data  = mk(16'h0080 + 16'(k), 1'b0, 1'b0);
      step();
    end
    chk("t3_full_ready", inst_ready, 1'b0);
    chk("t3_full_count", fifo_count, 4'd8);
    inst_data = mk(16'h00ff, 1'b0, 1'b0);
    step();
    inst_valid = 1'b0;
    chk("t3_ninth_rejected", fifo_count, 4'd8);
    chk("t3_still_busy", dut.state, ST_BUSY);
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    step();
    chk("t3_idle_full", inst_ready, 1'b0);
    step();
    chk("t3_pop_count", fifo_count, 4'd7);
    chk("t3_pop_ready", inst_ready, 1'b1);
    step();
    chk("t3_order_start", ap_start, 1'b1);
    chk("t3_order_inst", ctrl_instruction, mk(16'h0080, 1'b0, 1'b0));
    step();
    chk("t3_busy", dut.state, ST_BUSY);

    // Reset in the middle of a load.
    kernel_rst = 1'b1;
    step();
    kernel_rst = 1'b0;
    chk("t5_ap_start", ap_start, 1'b0);
    chk("t5_credits", dut.credits, 3'd2);
    chk("t5_fifo_count", fifo_count, 4'd0);
    chk("t5_idle", idle, 1'b1);
    chk("t5_ctrl_inst", ctrl_instruction, 96'h0);
`ifdef WEIGHT_DISPATCH_PERF_EN
    chk("t5_perf_inst", perf_inst_count, 16'd0);
    chk("t5_perf_busy", perf_busy_cycles, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
